// File: rtl/mul_pipe_pkg.sv
// Shared constants and helpers for the pipelined signed multiplier.
//
// Contents:
//   MAX_STAGE  - deepest pipeline the multiplier supports
//   prod_width - full-precision width of a signed a_width x b_width product
//
// Optional feature macro used by this slice: MUL_PIPE_SAT_EN
// (saturating output instead of two's-complement wrap).

package mul_pipe_pkg;

    localparam int MAX_STAGE = 4;

    // A signed a x b product always fits in a+b bits.
    function automatic int prod_width(input int a_width, input int b_width);
        return a_width + b_width;
    endfunction

endpackage

// File: rtl/mul_pipe_round_sat.sv
// Combinational round-half-up and output fitting for the multiplier result.
//
// Parameters:
//   PROD_WIDTH - width of the signed full-precision product
//   SHIFT      - fixed-point right shift, rounded half-up when non-zero
//   DOUT_WIDTH - width of the signed result
//
// Ports:
//   prod - signed full-precision product
//   dout - rounded result fitted into DOUT_WIDTH bits
//   sat  - result was clipped (always 0 in the wrapping build)
//
// Build option: define MUL_PIPE_SAT_EN to clamp out-of-range results to the
// nearest representable bound and flag them on sat. Without it the result
// wraps (low DOUT_WIDTH bits kept) and sat is tied low.

module mul_pipe_round_sat #(
    parameter int PROD_WIDTH = 18,
    parameter int SHIFT      = 0,
    parameter int DOUT_WIDTH = 13
) (
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int SUM_WIDTH = PROD_WIDTH + 1;
    // Wide enough to hold both the rounded value and the output bounds, with
    // a spare sign bit so the range compares are always exact.
    localparam int EXT_WIDTH = ((SUM_WIDTH > DOUT_WIDTH) ? SUM_WIDTH : DOUT_WIDTH) + 1;

    logic signed [SUM_WIDTH-1:0] prod_ext;
    logic signed [SUM_WIDTH-1:0] rnd;
    logic signed [EXT_WIDTH-1:0] rnd_ext;

    assign prod_ext = {prod[PROD_WIDTH-1], prod};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [SUM_WIDTH-1:0] HALF_LSB = SUM_WIDTH'(1) << (SHIFT - 1);

            logic signed [SUM_WIDTH-1:0] biased;

            assign biased = prod_ext + HALF_LSB;
            assign rnd    = biased >>> SHIFT;
        end else begin : g_no_round
            assign rnd = prod_ext;
        end
    endgenerate

    assign rnd_ext = {{(EXT_WIDTH - SUM_WIDTH){rnd[SUM_WIDTH-1]}}, rnd};

`ifdef MUL_PIPE_SAT_EN
    localparam logic signed [EXT_WIDTH-1:0] DOUT_MAX =
        {{(EXT_WIDTH - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
    // Bitwise inverse of 2^(N-1)-1 is -2^(N-1).
    localparam logic signed [EXT_WIDTH-1:0] DOUT_MIN = ~DOUT_MAX;

    always_comb begin
        dout = rnd_ext[DOUT_WIDTH-1:0];
        sat  = 1'b0;
        if (rnd_ext > DOUT_MAX) begin
            dout = DOUT_MAX[DOUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (rnd_ext < DOUT_MIN) begin
            dout = DOUT_MIN[DOUT_WIDTH-1:0];
            sat  = 1'b1;
        end
    end
`else
    // Upper bits are intentionally discarded by the wrap.
    logic unused_rnd_hi;

    assign unused_rnd_hi = ^rnd_ext[EXT_WIDTH-1:DOUT_WIDTH];
    assign dout          = rnd_ext[DOUT_WIDTH-1:0];
    assign sat           = 1'b0;
`endif

endmodule

// File: rtl/mul_pipe_rnd_sat.sv
// Pipelined signed multiplier with round-half-up shift and output fitting,
// using a valid/ready handshake on both sides.
//
// Parameters:
//   DIN0_WIDTH - signed width of operand A
//   DIN1_WIDTH - signed width of operand B
//   DOUT_WIDTH - signed width of the result
//   NUM_STAGE  - register stages from input to output (1..MAX_STAGE)
//   SHIFT      - fixed-point right shift applied to the product
//
// Ports:
//   ap_clk    - clock, rising edge
//   ap_rst_n  - asynchronous active-low reset
//   in_valid  - operands present
//   in_ready  - operands accepted this cycle
//   din0      - signed operand A
//   din1      - signed operand B
//   out_valid - result present
//   out_ready - downstream accepts the result
//   dout      - signed result
//   sat       - dout was clipped, qualified by out_valid
//
// Build option: MUL_PIPE_SAT_EN selects saturation instead of wrap in
// mul_pipe_round_sat.
//
// The multiply happens in the first stage and round/fit in the last; with a
// single stage both are in front of the one register. The whole pipe moves
// as a unit whenever the output register is empty or being drained.

module mul_pipe_rnd_sat
    import mul_pipe_pkg::*;
#(
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 13,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat
);

    localparam int PROD_WIDTH = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE) begin : g_bad_num_stage
            $error("mul_pipe_rnd_sat: NUM_STAGE must be within 1..MAX_STAGE");
        end
        if (SHIFT < 0 || SHIFT > PROD_WIDTH - 1) begin : g_bad_shift
            $error("mul_pipe_rnd_sat: SHIFT must be within 0..DIN0_WIDTH+DIN1_WIDTH-1");
        end
    endgenerate

    logic                  adv;
    logic [PROD_WIDTH-1:0] a_ext;
    logic [PROD_WIDTH-1:0] b_ext;
    logic [PROD_WIDTH-1:0] prod_in;
    logic [PROD_WIDTH-1:0] fit_prod;
    logic                  fit_valid;
    logic [DOUT_WIDTH-1:0] fit_dout;
    logic                  fit_sat;

    // Stall only when a result sits in the output register and nobody takes it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // The low PROD_WIDTH bits of the product of sign-extended operands equal
    // the signed product, and the signed product always fits in PROD_WIDTH.
    assign a_ext   = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
    assign b_ext   = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
    assign prod_in = a_ext * b_ext;

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign fit_prod  = prod_in;
            assign fit_valid = in_valid;
        end else begin : g_multi
            localparam int NPROD = NUM_STAGE - 1;

            logic [PROD_WIDTH-1:0] prod_q [NPROD];
            logic [NPROD-1:0]      vld_q;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < NPROD; i++) begin
                        prod_q[i] <= '0;
                    end
                end else if (adv) begin
                    vld_q[0]  <= in_valid;
                    prod_q[0] <= prod_in;
                    for (int i = 1; i < NPROD; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            assign fit_prod  = prod_q[NPROD-1];
            assign fit_valid = vld_q[NPROD-1];
        end
    endgenerate

    mul_pipe_round_sat #(
        .PROD_WIDTH (PROD_WIDTH),
        .SHIFT      (SHIFT),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_round_sat (
        .prod (fit_prod),
        .dout (fit_dout),
        .sat  (fit_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (adv) begin
            out_valid <= fit_valid;
            dout      <= fit_dout;
            sat       <= fit_sat;
        end
    end

endmodule

// File: tb/tb_mul_pipe_rnd_sat.sv
// Self-checking bench for mul_pipe_rnd_sat (default parameters, plus a
// SHIFT=2 instance for rounding). Follows MUL_PIPE_SAT_EN for expectations.

module tb_mul_pipe_rnd_sat;

    localparam int DW      = 13;
    localparam int OUT_MAX = (1 << (DW - 1)) - 1;
    localparam int OUT_MIN = -(1 << (DW - 1));

`ifdef MUL_PIPE_SAT_EN
    localparam int EXP_HI_D = 4095;
    localparam int EXP_HI_S = 1;
    localparam int EXP_LO_D = -4096;
    localparam int EXP_LO_S = 1;
`else
    localparam int EXP_HI_D = 0;
    localparam int EXP_HI_S = 0;
    localparam int EXP_LO_D = 512;
    localparam int EXP_LO_S = 0;
`endif

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [9:0]    din0;
    logic [7:0]    din1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic          sat;

    logic          s2_in_valid;
    logic          s2_in_ready;
    logic [9:0]    s2_din0;
    logic [7:0]    s2_din1;
    logic          s2_out_valid;
    logic          s2_out_ready;
    logic [DW-1:0] s2_dout;
    logic          s2_sat;

    int total = 0;
    int bad   = 0;
    int exp_d[$];
    int exp_s[$];
    int stall_dout;

    always #5 ap_clk = ~ap_clk;

    mul_pipe_rnd_sat dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat       (sat)
    );

    mul_pipe_rnd_sat #(.SHIFT(2)) dut_s2 (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (s2_in_valid),
        .in_ready  (s2_in_ready),
        .din0      (s2_din0),
        .din1      (s2_din1),
        .out_valid (s2_out_valid),
        .out_ready (s2_out_ready),
        .dout      (s2_dout),
        .sat       (s2_sat)
    );

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, expv, $time);
        end
    endtask

    // Reference: exact product, round half-up by shift, then clamp or wrap.
    function automatic void model(input int a, input int b, input int sh,
                                  output int d, output int s);
        longint p;
        longint r;
        logic signed [DW-1:0] w;
        p = longint'(a) * longint'(b);
        if (sh > 0) r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        else        r = p;
`ifdef MUL_PIPE_SAT_EN
        w = '0;
        if (r > longint'(OUT_MAX))      begin d = OUT_MAX; s = 1; end
        else if (r < longint'(OUT_MIN)) begin d = OUT_MIN; s = 1; end
        else                            begin d = int'(r); s = 0; end
`else
        w = r[DW-1:0];
        d = int'(w);
        s = 0;
`endif
    endfunction

    // Scoreboard compare on every falling edge.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_result_queue", 0, 1);
                end else begin
                    check("dout", int'($signed(dout)), exp_d[0]);
                    check("sat", int'(sat), exp_s[0]);
                    if (out_ready) begin
                        void'(exp_d.pop_front());
                        void'(exp_s.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                int d;
                int s;
                model(int'($signed(din0)), int'($signed(din1)), 0, d, s);
                exp_d.push_back(d);
                exp_s.push_back(s);
            end
        end
    end

    // Present operands from posedge+1 and hold until accepted.
    task automatic send(input int a, input int b);
        int  n    = 0;
        bit  done = 0;
        in_valid = 1'b1;
        din0     = 10'(a);
        din1     = 8'(b);
        while (!done) begin
            @(negedge ap_clk);
            done = in_ready;
            @(posedge ap_clk); #1;
            n++;
            if (!done && n > 50) begin
                check("send_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge ap_clk); #1;
            n++;
        end
        check({name, "_timeout"}, int'(out_valid), 1);
    endtask

    int va[13] = '{0, 1, -1, 511, -512, -512, 511, 100, -100, 63, 64, -64, -65};
    int vb[13] = '{0, 1, -1, 127, -128, 127, -128, 50, 50, 64, 64, 64, 63};

    initial begin
        ap_rst_n     = 1'b1;
        in_valid     = 1'b0;
        din0         = '0;
        din1         = '0;
        out_ready    = 1'b1;
        s2_in_valid  = 1'b0;
        s2_din0      = '0;
        s2_din1      = '0;
        s2_out_ready = 1'b1;

        // Reset state, checked before any clock edge.
        #1 ap_rst_n = 1'b0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_dout", int'(dout), 0);
        check("reset_sat", int'(sat), 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        // Back-to-back stream, two-cycle latency.
        in_valid = 1'b1; din0 = 10'(3); din1 = 8'(-5);
        @(posedge ap_clk); #1;
        check("lat_not_yet", int'(out_valid), 0);
        din0 = 10'(127); din1 = 8'(-1);
        @(posedge ap_clk); #1;
        check("lat_valid0", int'(out_valid), 1);
        check("lit_m15", int'($signed(dout)), -15);
        check("lit_m15_sat", int'(sat), 0);
        din0 = 10'(0); din1 = 8'(0);
        @(posedge ap_clk); #1;
        check("lit_m127", int'($signed(dout)), -127);
        in_valid = 1'b0;
        @(posedge ap_clk); #1;
        check("lat_valid2", int'(out_valid), 1);
        check("lit_zero", int'($signed(dout)), 0);
        @(posedge ap_clk); #1;
        check("bubble_empty", int'(out_valid), 0);

        // Extreme products.
        send(-512, -128);
        send(-512, 127);
        in_valid = 1'b0;
        wait_out("ext");
        check("lit_hi_dout", int'($signed(dout)), EXP_HI_D);
        check("lit_hi_sat", int'(sat), EXP_HI_S);
        @(posedge ap_clk); #1;
        check("lit_lo_dout", int'($signed(dout)), EXP_LO_D);
        check("lit_lo_sat", int'(sat), EXP_LO_S);
        @(posedge ap_clk); #1;

        // Rounding instance, SHIFT=2.
        s2_in_valid = 1'b1; s2_din0 = 10'(5); s2_din1 = 8'(3);
        @(posedge ap_clk); #1;
        s2_din0 = 10'(5); s2_din1 = 8'(1);
        @(posedge ap_clk); #1;
        check("s2_valid0", int'(s2_out_valid), 1);
        check("s2_5x3", int'($signed(s2_dout)), 4);
        s2_din0 = 10'(-5); s2_din1 = 8'(1);
        @(posedge ap_clk); #1;
        check("s2_5x1", int'($signed(s2_dout)), 1);
        s2_in_valid = 1'b0;
        @(posedge ap_clk); #1;
        check("s2_m5x1", int'($signed(s2_dout)), -1);
        check("s2_sat", int'(s2_sat), 0);
        @(posedge ap_clk); #1;

        // Three-cycle output stall with four operands offered.
        fork
            begin
                send(11, 2);
                send(12, 3);
                send(13, 4);
                send(14, 5);
                in_valid = 1'b0;
            end
            begin
                int n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge ap_clk); #1;
                    n++;
                end
                check("stall_start_valid", int'(out_valid), 1);
                out_ready  = 1'b0;
                stall_dout = int'($signed(dout));
                check("stall_first_dout", stall_dout, 22);
                repeat (3) begin
                    @(negedge ap_clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_dout_hold", int'($signed(dout)), stall_dout);
                end
                @(posedge ap_clk); #1;
                out_ready = 1'b1;
                repeat (4) begin
                    @(negedge ap_clk);
                    check("no_gap", int'(out_valid), 1);
                end
            end
        join
        @(posedge ap_clk); #1;

        // Boundary vectors under a fixed backpressure pattern.
        fork
            begin
                for (int i = 0; i < 13; i++) send(va[i], vb[i]);
                in_valid = 1'b0;
            end
            begin
                logic [15:0] pat;
                pat = 16'b1011_0111_1100_1101;
                for (int i = 0; i < 30; i++) begin
                    out_ready = pat[i % 16];
                    @(posedge ap_clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && exp_d.size() != 0; i++) begin
            @(posedge ap_clk); #1;
        end
        check("drain", exp_d.size(), 0);

        // Reset with two results in flight.
        send(21, 3);
        send(22, 3);
        in_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_dout", int'(dout), 0);
        exp_d.delete();
        exp_s.delete();
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        send(23, 3);
        in_valid = 1'b0;
        wait_out("post_rst");
        check("post_rst_dout", int'($signed(dout)), 69);
        @(posedge ap_clk); #1;
        check("post_rst_single", int'(out_valid), 0);
        check("final_drain", exp_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
